// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage with PC, variable-latency imem handshake and IF/ID register.
// Define DELAY_SLOT_EN for branch-delay-slot redirect instead of flush/DROP.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic [31:0] instruction,
  output logic        inst_valid
);
  localparam logic [1:0] BUSY = 2'd0, HOLD = 2'd1, DROP = 2'd2;
  logic [1:0]  state;
  logic [31:0] fetch_pc, hold_buf, seq_pc, next_pc, word;
  logic        just_reset, in_valid, deliver, flush;
`ifdef DELAY_SLOT_EN
  logic        pend_v;
  logic [31:0] pend_pc;
`endif
  assign imem_req  = state == BUSY;
  assign imem_addr = fetch_pc;
  always_comb begin
    // a valid straggling in from a pre-reset request must not be taken
    in_valid = imem_valid && !just_reset;
    seq_pc   = fetch_pc + 32'd4;
    word     = state == HOLD ? hold_buf : imem_rdata;
`ifdef DELAY_SLOT_EN
    flush    = 1'b0;
    next_pc  = redirect ? redirect_pc : pend_v ? pend_pc : seq_pc;
    deliver  = !stall && (state == HOLD || (state == BUSY && in_valid));
`else
    flush    = !stall && redirect;
    next_pc  = seq_pc;
    deliver  = !stall && !redirect && (state == HOLD || (state == BUSY && in_valid));
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BUSY;
      fetch_pc    <= RESET_PC;
      pc          <= 32'd0;
      pc_4        <= 32'd0;
      instruction <= NOP_INSTR;
      inst_valid  <= 1'b0;
      hold_buf    <= 32'd0;
      just_reset  <= 1'b1;
`ifdef DELAY_SLOT_EN
      pend_v      <= 1'b0;
      pend_pc     <= 32'd0;
`endif
    end else begin
      just_reset <= 1'b0;
      if (flush) begin
        fetch_pc    <= redirect_pc;
        pc          <= 32'd0;
        pc_4        <= 32'd0;
        instruction <= NOP_INSTR;
        inst_valid  <= 1'b0;
        state       <= (state != HOLD && !in_valid) ? DROP : BUSY;
      end else if (deliver) begin
        pc          <= fetch_pc;
        pc_4        <= seq_pc;
        instruction <= word;
        inst_valid  <= 1'b1;
        fetch_pc    <= next_pc;
        state       <= BUSY;
      end else begin
        if (!stall) inst_valid <= 1'b0;
        if (state == BUSY && stall && in_valid) begin
          hold_buf <= imem_rdata;
          state    <= HOLD;
        end
        if (state == DROP && in_valid) state <= BUSY;
      end
`ifdef DELAY_SLOT_EN
      if (deliver) pend_v <= 1'b0;
      else if (!stall && redirect) begin
        pend_v  <= 1'b1;
        pend_pc <= redirect_pc;
      end
`endif
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage with a latency-programmable memory returning word = address.
module tb_if_stage;
  logic        clk = 0, reset = 1, stall = 0, redirect = 0;
  logic [31:0] redirect_pc = 0;
  logic        imem_req, imem_valid, inst_valid;
  logic [31:0] imem_addr, imem_rdata, pc, pc_4, instruction;
  int          n_cmp = 0, n_err = 0, lat = 0, cnt = 0;
  logic        mbusy = 0;
  logic [31:0] maddr = 0;
  logic [31:0] sb[$];

  if_stage dut (.clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .pc(pc), .pc_4(pc_4),
    .instruction(instruction), .inst_valid(inst_valid));

  always #5 clk = ~clk;

  // memory: a request (held level or already latched) completes once cnt reaches lat
  assign imem_valid = (imem_req || mbusy) && cnt >= lat;
  assign imem_rdata = mbusy ? maddr : imem_addr;
  always @(posedge clk) begin
    if (reset) begin
      mbusy <= 0;
      cnt   <= 0;
    end else if (imem_valid) begin
      mbusy <= 0;
      cnt   <= 0;
    end else if (imem_req || mbusy) begin
      mbusy <= 1;
      cnt   <= cnt + 1;
      if (!mbusy) maddr <= imem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // a new IF/ID word exists after every un-stalled edge that leaves inst_valid high
  always begin
    logic s, r;
    logic [31:0] e;
    @(posedge clk);
    s = stall;
    r = reset;
    #1;
    if (!r && !s && inst_valid) begin
      if (sb.size() == 0) check("sb_extra", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        check("pc", pc, e);
        check("pc_4", pc_4, e + 32'd4);
        check("instr", instruction, e);
      end
    end
  end

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0) return;
    end
    check("timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'd0);
    check("rst_pc_4", pc_4, 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, 32'h3000);
    sb.push_back(32'h3000);
    sb.push_back(32'h3004);
    reset = 0;
    wait_empty(20);
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_req", {31'd0, imem_req}, 32'd0);
      check("hold_pc", pc, 32'h3004);
      check("hold_valid", {31'd0, inst_valid}, 32'd1);
    end
    stall = 0;
    lat = 2;
    sb.push_back(32'h3008);
    @(negedge clk);
    check("rel_pc", pc, 32'h3008);
    check("rel_addr", imem_addr, 32'h300C);
    check("rel_req", {31'd0, imem_req}, 32'd1);
    redirect = 1;
    redirect_pc = 32'h4000;
`ifdef DELAY_SLOT_EN
    sb.push_back(32'h300C);
`endif
    sb.push_back(32'h4000);
    @(negedge clk);
    redirect = 0;
`ifndef DELAY_SLOT_EN
    check("flush_valid", {31'd0, inst_valid}, 32'd0);
    check("flush_instr", instruction, 32'd0);
    check("drop_req", {31'd0, imem_req}, 32'd0);
    check("drop_addr", imem_addr, 32'h4000);
`endif
    wait_empty(20);
    redirect = 1;
    redirect_pc = 32'hFFFF_FFFC;
`ifdef DELAY_SLOT_EN
    sb.push_back(32'h4004);
`endif
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0000_0000);
    @(negedge clk);
    redirect = 0;
    wait_empty(30);
    stall = 1;
    repeat (4) @(negedge clk);
    check("sb_left", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
